// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline control slice: FSM state encoding and
// register-index constants used by the hazard logic.
package pipe_ctrl_pkg;

   // Width of an architectural register index.
   localparam int REG_W = 5;

   // $zero is never a real dependency because writes to it are discarded.
   localparam logic [REG_W-1:0] REG_ZERO = 5'd0;

   // Hazard sequencer states.
   typedef enum logic {
      ST_RUN      = 1'b0,
      ST_MEM_WAIT = 1'b1
   } ctrlState_t;

endpackage

// File: rtl/haz_load_use_det.sv
// Load-use hazard detector: purely combinational compare between the load
// sitting in EX and the source registers of the instruction in ID.
// Kept stand-alone so the forwarding unit bench can reuse it.
module haz_load_use_det
   import pipe_ctrl_pkg::*;
(
   input  logic             idexMemRead,
   input  logic [REG_W-1:0] idexRt,
   input  logic [REG_W-1:0] ifidRs,
   input  logic [REG_W-1:0] ifidRt,
   input  logic             ifidUsesRt,
   output logic             loadUse
);

   logic rsMatch;
   logic rtMatch;

   // rs is always a source; rt only counts when the ID instruction reads it.
   assign rsMatch = (idexRt == ifidRs);
   assign rtMatch = ifidUsesRt && (idexRt == ifidRt);

   // A load into $zero produces no usable value, so it never stalls.
   assign loadUse = idexMemRead && (idexRt != REG_ZERO) && (rsMatch || rtMatch);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Central stall/flush sequencer for the 5-stage pipeline. Handles load-use
// bubbles, taken-branch flushes and data-cache miss freezes, with a watchdog
// that flags a memory access hung longer than MEM_TIMEOUT cycles.
// Optional build macro HAZ_PERF_CNT_EN adds bubble/flush/freeze cycle counters.
module pipe_hazard_ctrl
   import pipe_ctrl_pkg::*;
#(
   parameter int MEM_TIMEOUT = 255,
   parameter int CNT_W       = 8
)
(
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic [REG_W-1:0] ifid_rs_i,
   input  logic [REG_W-1:0] ifid_rt_i,
   input  logic             ifid_uses_rt_i,
   input  logic             idex_memread_i,
   input  logic [REG_W-1:0] idex_rt_i,
   input  logic             branch_taken_i,
   input  logic             mem_req_i,
   input  logic             mem_ack_i,
   output logic             pc_write_o,
   output logic             ifid_stall_o,
   output logic             ifid_flush_o,
   output logic             idex_stall_o,
   output logic             idex_bubble_o,
   output logic             exmem_stall_o,
   output logic             memwb_stall_o,
   output logic             busy_o,
`ifdef HAZ_PERF_CNT_EN
   output logic [31:0]      perf_bubble_o,
   output logic [31:0]      perf_flush_o,
   output logic [31:0]      perf_memstall_o,
`endif
   output logic             err_o
);

   localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(MEM_TIMEOUT);

   ctrlState_t       stateReg;
   ctrlState_t       stateNext;
   logic [CNT_W-1:0] wcntReg;
   logic [CNT_W-1:0] wcntNext;
   logic             errReg;
   logic             errNext;

   logic             loadUse;
   logic             missPending;
   logic             freeze;

   logic             pcWrite;
   logic             ifidStall;
   logic             ifidFlush;
   logic             idexStall;
   logic             idexBubble;
   logic             exmemStall;
   logic             memwbStall;

   haz_load_use_det uLoadUse (
      .idexMemRead (idex_memread_i),
      .idexRt      (idex_rt_i),
      .ifidRs      (ifid_rs_i),
      .ifidRt      (ifid_rt_i),
      .ifidUsesRt  (ifid_uses_rt_i),
      .loadUse     (loadUse)
   );

   // A hit or same-cycle fill (ack with req) is not a miss; in MEM_WAIT a
   // dropped request is taken as completion too.
   assign missPending = mem_req_i && !mem_ack_i;

   // Next-state, watchdog and raw control decode; miss beats load-use beats branch.
   always_comb begin
      stateNext  = stateReg;
      wcntNext   = wcntReg;
      errNext    = errReg;
      freeze     = 1'b0;
      pcWrite    = 1'b0;
      ifidStall  = 1'b0;
      ifidFlush  = 1'b0;
      idexStall  = 1'b0;
      idexBubble = 1'b0;
      exmemStall = 1'b0;
      memwbStall = 1'b0;
      case (stateReg)
         ST_RUN: begin
            if (missPending) begin
               ifidStall  = 1'b1;
               idexStall  = 1'b1;
               exmemStall = 1'b1;
               memwbStall = 1'b1;
               stateNext  = ST_MEM_WAIT;
               wcntNext   = CNT_W'(1);
            end else if (loadUse) begin
               // Hold the dependent instruction one cycle; the load moves to
               // MEM meanwhile, so the hazard clears on its own next cycle.
               ifidStall  = 1'b1;
               idexBubble = 1'b1;
            end else if (branch_taken_i) begin
               ifidFlush  = 1'b1;
               pcWrite    = 1'b1;
            end else begin
               pcWrite    = 1'b1;
            end
         end
         ST_MEM_WAIT: begin
            // Hazard/branch inputs are ignored here: IF/ID is frozen, so they
            // are re-evaluated in the first RUN cycle after the fill.
            if (missPending) begin
               freeze     = 1'b1;
               ifidStall  = 1'b1;
               idexStall  = 1'b1;
               exmemStall = 1'b1;
               memwbStall = 1'b1;
               if (wcntReg != TIMEOUT_CNT) begin
                  wcntNext = wcntReg + 1'b1;
               end
            end else begin
               // Release everything this cycle so the pipe advances at the edge.
               pcWrite   = 1'b1;
               stateNext = ST_RUN;
               wcntNext  = '0;
            end
         end
         default: begin
            stateNext = ST_RUN;
            wcntNext  = '0;
         end
      endcase
      // err rises together with the count reaching the limit and stays set.
      if ((stateNext == ST_MEM_WAIT) && (wcntNext == TIMEOUT_CNT)) begin
         errNext = 1'b1;
      end
   end

   // State, wait counter and sticky watchdog flag.
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         stateReg <= ST_RUN;
         wcntReg  <= '0;
         errReg   <= 1'b0;
      end else begin
         stateReg <= stateNext;
         wcntReg  <= wcntNext;
         errReg   <= errNext;
      end
   end

   // All pipeline controls are held inactive while reset is asserted.
   assign pc_write_o    = rst_i && pcWrite;
   assign ifid_stall_o  = rst_i && ifidStall;
   assign ifid_flush_o  = rst_i && ifidFlush;
   assign idex_stall_o  = rst_i && idexStall;
   assign idex_bubble_o = rst_i && idexBubble;
   assign exmem_stall_o = rst_i && exmemStall;
   assign memwb_stall_o = rst_i && memwbStall;
   assign busy_o        = (stateReg == ST_MEM_WAIT);
   assign err_o         = errReg;

`ifdef HAZ_PERF_CNT_EN
   logic [31:0] perfBubbleReg;
   logic [31:0] perfFlushReg;
   logic [31:0] perfMemStallReg;

   // Free-running event counters, wrapping modulo 2^32.
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         perfBubbleReg   <= '0;
         perfFlushReg    <= '0;
         perfMemStallReg <= '0;
      end else begin
         if (idexBubble) begin
            perfBubbleReg <= perfBubbleReg + 32'd1;
         end
         if (ifidFlush) begin
            perfFlushReg <= perfFlushReg + 32'd1;
         end
         if (freeze) begin
            perfMemStallReg <= perfMemStallReg + 32'd1;
         end
      end
   end

   assign perf_bubble_o   = perfBubbleReg;
   assign perf_flush_o    = perfFlushReg;
   assign perf_memstall_o = perfMemStallReg;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl (watchdog limit shortened to 4).
// Expected output vectors come from a small cycle model, are queued when the
// stimulus is applied and popped when the DUT outputs are sampled.
module tb_pipe_hazard_ctrl;

   localparam int TO = 4;

   logic       clk = 1'b0;
   logic       rst_i = 1'b1;
   logic [4:0] ifid_rs_i = '0;
   logic [4:0] ifid_rt_i = '0;
   logic       ifid_uses_rt_i = 1'b0;
   logic       idex_memread_i = 1'b0;
   logic [4:0] idex_rt_i = '0;
   logic       branch_taken_i = 1'b0;
   logic       mem_req_i = 1'b0;
   logic       mem_ack_i = 1'b0;

   logic pc_write_o, ifid_stall_o, ifid_flush_o, idex_stall_o, idex_bubble_o;
   logic exmem_stall_o, memwb_stall_o, busy_o, err_o;
`ifdef HAZ_PERF_CNT_EN
   logic [31:0] perf_bubble_o, perf_flush_o, perf_memstall_o;
`endif

   // {pc_write, ifid_stall, ifid_flush, idex_stall, idex_bubble, exmem_stall, memwb_stall, busy, err}
   logic [8:0] obs;
   assign obs = {pc_write_o, ifid_stall_o, ifid_flush_o, idex_stall_o, idex_bubble_o,
                 exmem_stall_o, memwb_stall_o, busy_o, err_o};

   typedef struct {
      string      name;
      logic [8:0] exp;
   } vec_t;

   vec_t sbQ[$];
   int   nVec = 0;
   int   nMis = 0;

   // Reference model state
   int   mState = 0;  // 0 = RUN, 1 = MEM_WAIT
   int   mCnt   = 0;
   logic mErr   = 1'b0;

   pipe_hazard_ctrl #(.MEM_TIMEOUT(TO), .CNT_W(8)) dut (
      .clk_i          (clk),
      .rst_i          (rst_i),
      .ifid_rs_i      (ifid_rs_i),
      .ifid_rt_i      (ifid_rt_i),
      .ifid_uses_rt_i (ifid_uses_rt_i),
      .idex_memread_i (idex_memread_i),
      .idex_rt_i      (idex_rt_i),
      .branch_taken_i (branch_taken_i),
      .mem_req_i      (mem_req_i),
      .mem_ack_i      (mem_ack_i),
      .pc_write_o     (pc_write_o),
      .ifid_stall_o   (ifid_stall_o),
      .ifid_flush_o   (ifid_flush_o),
      .idex_stall_o   (idex_stall_o),
      .idex_bubble_o  (idex_bubble_o),
      .exmem_stall_o  (exmem_stall_o),
      .memwb_stall_o  (memwb_stall_o),
      .busy_o         (busy_o),
`ifdef HAZ_PERF_CNT_EN
      .perf_bubble_o  (perf_bubble_o),
      .perf_flush_o   (perf_flush_o),
      .perf_memstall_o(perf_memstall_o),
`endif
      .err_o          (err_o)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL timeout: bench did not finish, got running want finished");
      $fatal(1);
   end

   // Expected outputs for the current inputs and model state.
   function automatic logic [8:0] modelOut();
      logic lu;
      if (!rst_i) return 9'b0;
      lu = idex_memread_i && (idex_rt_i != 5'd0) &&
           ((idex_rt_i == ifid_rs_i) || (ifid_uses_rt_i && (idex_rt_i == ifid_rt_i)));
      if (mState == 0) begin
         if (mem_req_i && !mem_ack_i) return {8'b0_1_0_1_0_1_1_0, mErr};
         if (lu)                      return {8'b0_1_0_0_1_0_0_0, mErr};
         if (branch_taken_i)          return {8'b1_0_1_0_0_0_0_0, mErr};
         return {8'b1_0_0_0_0_0_0_0, mErr};
      end
      if (mem_req_i && !mem_ack_i) return {8'b0_1_0_1_0_1_1_1, mErr};
      return {8'b1_0_0_0_0_0_0_1, mErr};
   endfunction

   // Model state update at a rising edge.
   task automatic modelClock();
      if (!rst_i) begin
         mState = 0; mCnt = 0; mErr = 1'b0;
      end else if (mState == 0) begin
         if (mem_req_i && !mem_ack_i) begin
            mState = 1; mCnt = 1;
            if (mCnt == TO) mErr = 1'b1;
         end
      end else begin
         if (mem_req_i && !mem_ack_i) begin
            if (mCnt < TO) mCnt = mCnt + 1;
            if (mCnt == TO) mErr = 1'b1;
         end else begin
            mState = 0; mCnt = 0;
         end
      end
   endtask

   task automatic setIn(input logic mr, input logic [4:0] irt, input logic [4:0] rs,
                        input logic [4:0] rt, input logic urt, input logic br,
                        input logic req, input logic ack);
      idex_memread_i = mr;  idex_rt_i = irt; ifid_rs_i = rs; ifid_rt_i = rt;
      ifid_uses_rt_i = urt; branch_taken_i = br; mem_req_i = req; mem_ack_i = ack;
   endtask

   // Queue the expectation for the applied inputs, then move to the sample point.
   task automatic drive(input string name);
      vec_t v;
      v.name = name;
      v.exp  = modelOut();
      sbQ.push_back(v);
      @(negedge clk);
   endtask

   task automatic advance();
      @(posedge clk);
      modelClock();
      #1;
   endtask

   task automatic test_reset();
      vec_t v;
      for (int i = 0; i < 3; i++) begin
         case (i)
            0: begin #1; rst_i = 1'b0; setIn(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0); end
            1: setIn(1'b1, 5'd8, 5'd8, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0);
            default: begin rst_i = 1'b1; setIn(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0); end
         endcase
         drive($sformatf("reset[%0d]", i));
         v = sbQ.pop_front();
         nVec++;
         if (obs !== v.exp) begin
            nMis++;
            $display("FAIL %s: got %b want %b", v.name, obs, v.exp);
         end else $display("vec %0d %s out=%b", nVec, v.name, obs);
         advance();
      end
   endtask

   task automatic test_load_use();
      vec_t v;
      for (int i = 0; i < 7; i++) begin
         case (i)
            0: setIn(1'b1, 5'd8, 5'd8, 5'd3, 1'b0, 1'b0, 1'b0, 1'b0); // rs hazard
            1: setIn(1'b0, 5'd8, 5'd8, 5'd3, 1'b0, 1'b0, 1'b0, 1'b0); // load moved on
            2: setIn(1'b1, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0); // $zero never stalls
            3: setIn(1'b1, 5'd8, 5'd3, 5'd8, 1'b0, 1'b0, 1'b0, 1'b0); // rt not read
            4: setIn(1'b1, 5'd8, 5'd3, 5'd8, 1'b1, 1'b0, 1'b0, 1'b0); // rt hazard
            5: setIn(1'b0, 5'd8, 5'd3, 5'd8, 1'b1, 1'b0, 1'b0, 1'b0);
            default: setIn(1'b0, 5'd8, 5'd8, 5'd8, 1'b1, 1'b0, 1'b0, 1'b0); // not a load
         endcase
         drive($sformatf("load_use[%0d]", i));
         v = sbQ.pop_front();
         nVec++;
         if (obs !== v.exp) begin
            nMis++;
            $display("FAIL %s: got %b want %b", v.name, obs, v.exp);
         end else $display("vec %0d %s out=%b", nVec, v.name, obs);
         advance();
      end
   endtask

   task automatic test_branch();
      vec_t v;
      for (int i = 0; i < 5; i++) begin
         case (i)
            0: setIn(1'b0, 5'd0, 5'd1, 5'd2, 1'b1, 1'b1, 1'b0, 1'b0); // plain taken branch
            1: setIn(1'b0, 5'd0, 5'd1, 5'd2, 1'b1, 1'b0, 1'b0, 1'b0);
            2: setIn(1'b1, 5'd9, 5'd9, 5'd2, 1'b1, 1'b1, 1'b0, 1'b0); // branch + load-use
            3: setIn(1'b0, 5'd9, 5'd9, 5'd2, 1'b1, 1'b1, 1'b0, 1'b0); // re-resolved, flushes
            default: setIn(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
         endcase
         drive($sformatf("branch[%0d]", i));
         v = sbQ.pop_front();
         nVec++;
         if (obs !== v.exp) begin
            nMis++;
            $display("FAIL %s: got %b want %b", v.name, obs, v.exp);
         end else $display("vec %0d %s out=%b", nVec, v.name, obs);
         advance();
      end
   endtask

   task automatic test_miss();
      vec_t v;
      for (int i = 0; i < 15; i++) begin
         case (i)
            0, 1:    setIn(1'b1, 5'd8, 5'd8, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0); // miss + load-use + branch
            2:       setIn(1'b1, 5'd8, 5'd8, 5'd0, 1'b0, 1'b1, 1'b1, 1'b1); // fill
            3:       setIn(1'b1, 5'd8, 5'd8, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0); // load-use re-evaluated
            4:       setIn(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1); // hit: no miss
            5:       setIn(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
            6:       setIn(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0); // req dropped = ack
            7:       setIn(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
            8, 9, 10, 11: setIn(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
            12:      setIn(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1); // ack on 5th
            default: setIn(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
         endcase
         drive($sformatf("miss[%0d]", i));
         v = sbQ.pop_front();
         nVec++;
         if (obs !== v.exp) begin
            nMis++;
            $display("FAIL %s: got %b want %b", v.name, obs, v.exp);
         end else $display("vec %0d %s out=%b", nVec, v.name, obs);
         advance();
      end
   endtask

   task automatic test_async_reset();
      vec_t v;
      for (int i = 0; i < 5; i++) begin
         case (i)
            0, 1, 2: setIn(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
            3: begin
               // drop reset between edges while frozen in MEM_WAIT
               #2;
               rst_i = 1'b0;
               #1;
            end
            default: begin rst_i = 1'b1; setIn(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0); end
         endcase
         if (i == 3) begin
            v.name = "async_reset[3]";
            v.exp  = modelOut();
            sbQ.push_back(v);
            mState = 0; mCnt = 0; mErr = 1'b0;
         end else begin
            drive($sformatf("async_reset[%0d]", i));
         end
         v = sbQ.pop_front();
         nVec++;
         if (obs !== v.exp) begin
            nMis++;
            $display("FAIL %s: got %b want %b", v.name, obs, v.exp);
         end else $display("vec %0d %s out=%b", nVec, v.name, obs);
         if (i == 3) @(negedge clk);
         advance();
      end
   endtask

   task automatic test_watchdog();
      vec_t v;
      for (int i = 0; i < 9; i++) begin
         case (i)
            0, 1, 2, 3, 4, 5: setIn(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
            6:       setIn(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1);
            7:       setIn(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
            default: setIn(1'b1, 5'd4, 5'd4, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
         endcase
         drive($sformatf("watchdog[%0d]", i));
         v = sbQ.pop_front();
         nVec++;
         if (obs !== v.exp) begin
            nMis++;
            $display("FAIL %s: got %b want %b", v.name, obs, v.exp);
         end else $display("vec %0d %s out=%b", nVec, v.name, obs);
         advance();
      end
   endtask

`ifdef HAZ_PERF_CNT_EN
   task automatic test_perf();
      vec_t v;
      test_async_reset();
      for (int i = 0; i < 16; i++) begin
         case (i)
            0, 2:        setIn(1'b1, 5'd8, 5'd8, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
            4, 5, 7:     setIn(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
            9, 10, 11, 12, 13: setIn(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
            14:          setIn(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1);
            default:     setIn(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
         endcase
         drive($sformatf("perf[%0d]", i));
         v = sbQ.pop_front();
         nVec++;
         if (obs !== v.exp) begin
            nMis++;
            $display("FAIL %s: got %b want %b", v.name, obs, v.exp);
         end else $display("vec %0d %s out=%b", nVec, v.name, obs);
         advance();
      end
      @(negedge clk);
      nVec++;
      if (perf_bubble_o !== 32'd2) begin
         nMis++;
         $display("FAIL perf_bubble: got %0d want 2", perf_bubble_o);
      end else $display("vec %0d perf_bubble=%0d", nVec, perf_bubble_o);
      nVec++;
      if (perf_flush_o !== 32'd3) begin
         nMis++;
         $display("FAIL perf_flush: got %0d want 3", perf_flush_o);
      end else $display("vec %0d perf_flush=%0d", nVec, perf_flush_o);
      nVec++;
      if (perf_memstall_o !== 32'd4) begin
         nMis++;
         $display("FAIL perf_memstall: got %0d want 4", perf_memstall_o);
      end else $display("vec %0d perf_memstall=%0d", nVec, perf_memstall_o);
   endtask
`endif

   initial begin
      test_reset();
      test_load_use();
      test_branch();
      test_miss();
      test_async_reset();
      test_watchdog();
      test_async_reset();
`ifdef HAZ_PERF_CNT_EN
      test_perf();
`endif
      $display("== %0d vectors applied, %0d miscompares ==", nVec, nMis);
      $finish;
   end

endmodule
